snn_image_loader: RTL and testbench



---
 rtl/snn_image_loader.sv | 186 ++++++++++++++++++
 tb/tb_snn_image_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_image_loader.sv
// snn_image_loader: receives a 98-byte binary image, streams its 784 pixels into the
// input-unit RAM, starts the SNN core and returns the classified digit as ASCII.
`default_nettype none

module snn_image_loader #(
    parameter int          NUM_PIX    = 784,
    parameter logic [7:0]  ASCII_BASE = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] core_addr,
    input  logic       done,
    input  logic [3:0] digit,
    input  logic       tx_done,
    output logic [9:0] ram_addr,
    output logic       ram_data,
    output logic       ram_we,
    output logic       start,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overrun
);

    localparam logic [9:0] LAST_PIX = 10'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_TX        = 3'd4,
        S_TX_WAIT   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] pix_cnt_q, pix_cnt_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       overrun_q, overrun_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       ram_we_q, start_q, tx_start_q, busy_q;

    logic       last_beat;
    logic       last_pix;
    logic       pend_load;

    assign last_beat = (bit_cnt_q == 3'd7);
    assign last_pix  = (pix_cnt_q == LAST_PIX);
    assign pend_load = (state_q == S_WRITE) && last_beat && !last_pix && pend_vld_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        byte_cnt_d = byte_cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overrun_d  = overrun_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (rx_rdy) begin
                    shift_d   = rx_data;
                    bit_cnt_d = 3'd0;
                    state_d   = S_WRITE;
                    if (byte_cnt_q == 7'd0) begin
                        overrun_d = 1'b0;
                    end
                end
            end

            S_WRITE: begin
                shift_d   = {1'b0, shift_q[7:1]};
                pix_cnt_d = pix_cnt_q + 10'd1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (last_beat) begin
                    byte_cnt_d = byte_cnt_q + 7'd1;
                    if (last_pix) begin
                        state_d = S_START;
                    end else if (pend_vld_q) begin
                        shift_d    = pend_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                if (rx_rdy) begin
                    // A byte landing on the final beat of an idle-bound byte chains
                    // straight into the shifter so it is not stranded in the buffer.
                    if (last_beat && !last_pix && !pend_vld_q) begin
                        shift_d = rx_data;
                        state_d = S_WRITE;
                    end else if (!pend_vld_q || pend_load) begin
                        pend_d     = rx_data;
                        pend_vld_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end

            S_START: begin
                state_d = S_WAIT_DONE;
                if (rx_rdy) overrun_d = 1'b1;
            end

            S_WAIT_DONE: begin
                if (done) begin
                    tx_data_d = ASCII_BASE + {4'h0, digit};
                    state_d   = S_TX;
                end
                if (rx_rdy) overrun_d = 1'b1;
            end

            S_TX: begin
                state_d = S_TX_WAIT;
                if (rx_rdy) overrun_d = 1'b1;
            end

            S_TX_WAIT: begin
                if (tx_done) begin
                    pix_cnt_d  = 10'd0;
                    byte_cnt_d = 7'd0;
                    pend_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end
                if (rx_rdy) overrun_d = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            pix_cnt_q  <= 10'd0;
            byte_cnt_q <= 7'd0;
            pend_q     <= 8'h00;
            pend_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            ram_we_q   <= 1'b0;
            start_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            overrun_q  <= overrun_d;
            tx_data_q  <= tx_data_d;
            ram_we_q   <= (state_d == S_WRITE);
            start_q    <= (state_d == S_START);
            tx_start_q <= (state_d == S_TX);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // The core owns the RAM address only while it is classifying.
    assign ram_addr = (state_q == S_WAIT_DONE) ? core_addr : pix_cnt_q;
    assign ram_data = shift_q[0];
    assign ram_we   = ram_we_q;
    assign start    = start_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_snn_image_loader.sv
// tb_snn_image_loader: scoreboard bench for snn_image_loader; expected RAM writes are
// queued as bytes are sent and compared as the loader performs them.
`default_nettype none

module tb_snn_image_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] core_addr = 10'd0;
    logic       done = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       tx_done = 1'b0;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic       start;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;

    snn_image_loader #(.NUM_PIX(784), .ASCII_BASE(8'h30)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .core_addr (core_addr),
        .done      (done),
        .digit     (digit),
        .tx_done   (tx_done),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .start     (start),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [10:0] exp_q[$];
    int          pix_m = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          last_cyc = -1;
    int          start_cyc = -1;
    int          start_cnt = 0;
    int          txs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({10'(pix_m), b[i]});
            pix_m++;
        end
    endtask

    // One-cycle rx pulse; returns 1ns into the first write beat.
    task automatic send(input logic [7:0] b, input bit expect_write);
        @(posedge clk); #1;
        rx_rdy  = 1'b1;
        rx_data = b;
        if (expect_write) push_byte(b);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                logic [10:0] e;
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ram_wr", {21'd0, ram_addr, ram_data}, {21'd0, e});
                end
                wr_cnt++;
                if (ram_addr == 10'd783) last_cyc = cyc;
            end
            if (start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (tx_start) txs_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int first_c;
        int last_c;

        // reset values
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_start", start, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(2);

        // single byte A5: 8 beats, busy only during them
        send(8'hA5, 1'b1);
        b = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) b++;
        end
        chk("a5_busy_cycles", b, 8);
        chk("a5_sb_empty", exp_q.size(), 0);

        // fill to pixel 96, then reset on the beat writing pixel 100
        while (pix_m < 96) begin
            send(8'($urandom), 1'b1);
            tick(10);
        end
        send(8'hFF, 1'b1);
        tick(4);
        chk("pre_rst_addr", ram_addr, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        pix_m = 0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // full image of 98 bytes spaced 12 cycles apart
        wr_cnt = 0;
        for (int k = 0; k < 98; k++) begin
            send(8'($urandom), 1'b1);
            tick(10);
        end
        for (int k = 0; k < 40 && start_cnt == 0; k++) @(negedge clk);
        tick(5);
        chk("start_once", start_cnt, 1);
        chk("start_latency", start_cyc - last_cyc, 1);
        chk("img_wr_cnt", wr_cnt, 784);
        chk("img_sb_empty", exp_q.size(), 0);
        core_addr = 10'h155;
        @(negedge clk);
        chk("wait_core_addr", ram_addr, 10'h155);
        chk("wait_busy", busy, 1);

        // byte during WAIT_DONE is dropped
        send(8'h5A, 1'b0);
        @(negedge clk);
        chk("wait_overrun", overrun, 1);

        // done with digit 7
        @(posedge clk); #1;
        done  = 1'b1;
        digit = 4'd7;
        @(posedge clk); #1;
        done = 1'b0;
        chk("tx_start", tx_start, 1);
        chk("tx_data", tx_data, 8'h37);
        chk("tx_pix_unchanged", ram_addr, 784);
        tick(3);
        chk("tx_data_hold", tx_data, 8'h37);
        chk("tx_start_once", txs_cnt, 1);

        // tx_done returns to IDLE; next image starts at 0 with overrun cleared
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        chk("txdone_busy", busy, 0);
        chk("overrun_held", overrun, 1);
        pix_m = 0;
        send(8'h3C, 1'b1);
        chk("new_img_overrun", overrun, 0);
        chk("new_img_addr", ram_addr, 0);
        tick(10);

        // three back-to-back bytes: 1 written, 2 chained, 3 dropped
        @(posedge clk); #1;
        rx_rdy  = 1'b1;
        rx_data = 8'hC3;
        push_byte(8'hC3);
        @(posedge clk); #1;
        rx_data = 8'h96;
        push_byte(8'h96);
        @(posedge clk); #1;
        rx_data = 8'hFF;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        b       = 0;
        first_c = -1;
        last_c  = -1;
        repeat (20) begin
            @(negedge clk);
            if (ram_we) begin
                b++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
        end
        chk("b2b_count", b, 14);
        chk("b2b_span", last_c - first_c, 13);
        chk("b2b_overrun", overrun, 1);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
